// File: rtl/wave_dac_pkg.sv
// wave_dac_pkg: FSM states, DAC frame constants and frame builder shared by the wave DAC driver.
package wave_dac_pkg;
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SHIFT, LATCH} state_e;
    localparam logic [3:0] DAC_CFG_BITS = 4'b0011;
    localparam int FRAME_W = 16;
    localparam logic [11:0] MIDSCALE = 12'h800;
    function automatic logic [FRAME_W-1:0] make_frame(input logic [11:0] d);
        return {DAC_CFG_BITS, d};
    endfunction
endpackage

// File: rtl/wave_dac_if.sv
// wave_dac_if: wavetable RAM handshake plus SPI DAC pins; master = driver side.
interface wave_dac_if #(parameter int DATA_W = 12);
    logic [12:0] waveram_address;
    logic [DATA_W-1:0] waveram_data;
    logic [12:0] waveram_read_address;
    logic waveram_read_enable;
    logic dac_cs_n;
    logic dac_sclk;
    logic dac_sdi;
    logic dac_ldac_n;
    modport master(
        input waveram_address, waveram_data,
        output waveram_read_address, waveram_read_enable, dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n
    );
    modport slave(
        output waveram_address, waveram_data,
        input waveram_read_address, waveram_read_enable, dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n
    );
endinterface

// File: rtl/dac_frame_shifter.sv
// dac_frame_shifter: shifts one 16-bit frame out MSB first, each bit SCLK low then high for SCLK_DIV cycles.
module dac_frame_shifter
    import wave_dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_word,
    output logic               o_cs_n,
    output logic               o_sclk,
    output logic               o_sdi,
    output logic               o_done
);
    localparam int DW = $clog2(SCLK_DIV) + 1;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0] bit_q, bit_d;
    logic sclk_q, sclk_d, cs_n_q, cs_n_d, phase_end, last;
    always_comb begin
        phase_end = !cs_n_q && div_q == DW'(SCLK_DIV - 1);
        last = phase_end && sclk_q && bit_q == 4'(FRAME_W - 1);
        sh_d = sh_q;
        div_d = div_q;
        bit_d = bit_q;
        sclk_d = sclk_q;
        cs_n_d = cs_n_q;
        if (i_load) begin
            sh_d = i_word;
            div_d = '0;
            bit_d = '0;
            sclk_d = 1'b0;
            cs_n_d = 1'b0;
        end else if (!cs_n_q) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
            sclk_d = phase_end ? !sclk_q : sclk_q;
            // data only moves on the falling SCLK edge so the DAC samples a stable bit
            if (phase_end && sclk_q) begin
                sh_d = sh_q << 1;
                bit_d = bit_q + 1'b1;
                cs_n_d = last;
            end
        end
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sh_q <= '0;
            div_q <= '0;
            bit_q <= '0;
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            sh_q <= sh_d;
            div_q <= div_d;
            bit_q <= bit_d;
            sclk_q <= sclk_d;
            cs_n_q <= cs_n_d;
        end
    end
    assign o_cs_n = cs_n_q;
    assign o_sclk = sclk_q;
    assign o_sdi = sh_q[FRAME_W-1];
    assign o_done = last;
endmodule

// File: rtl/wave_dac_driver.sv
// wave_dac_driver: sample-rate timer, wavetable read and SPI DAC frame with LDAC latch.
// Optional DAC_MUTE_EN: i_mute at frame start sends midscale and skips the RAM read.
module wave_dac_driver
    import wave_dac_pkg::*;
#(
    parameter int SAMPLE_DIV = 512,
    parameter int SCLK_DIV   = 2,
    parameter int DATA_W     = 12
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_mute,
    wave_dac_if.master bus,
    output logic       o_busy,
    output logic       o_overrun
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int LW = $clog2(SCLK_DIV) + 1;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [12:0] addr_q, addr_d;
    logic pending_q, pending_d, overrun_q, overrun_d, re_q, re_d, mute_q, mute_d;
    logic tick, load, done, mute_now;
    logic [FRAME_W-1:0] word;
`ifdef DAC_MUTE_EN
    assign mute_now = i_mute;
`else
    logic unused_mute;
    assign unused_mute = i_mute;
    assign mute_now = 1'b0;
`endif
    always_comb begin
        tick = i_enable && cnt_q == CW'(SAMPLE_DIV - 1);
        cnt_d = (!i_enable || tick) ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        lcnt_d = lcnt_q;
        addr_d = addr_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        mute_d = mute_q;
        re_d = 1'b0;
        load = 1'b0;
        // a tick during a frame is queued once; a second one is lost and flagged
        if (state_q != IDLE && tick) begin
            pending_d = 1'b1;
            overrun_d = overrun_q || pending_q;
        end
        case (state_q)
            IDLE: if (tick || pending_q) begin
                state_d = READ;
                pending_d = 1'b0;
                addr_d = bus.waveram_address;
                mute_d = mute_now;
                re_d = !mute_now;
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                state_d = SHIFT;
                load = 1'b1;
            end
            SHIFT: if (done) begin
                state_d = LATCH;
                lcnt_d = '0;
            end
            LATCH: begin
                lcnt_d = lcnt_q + 1'b1;
                state_d = lcnt_q == LW'(SCLK_DIV - 1) ? IDLE : LATCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            lcnt_q <= '0;
            addr_q <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            mute_q <= 1'b0;
            re_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            lcnt_q <= lcnt_d;
            addr_q <= addr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mute_q <= mute_d;
            re_q <= re_d;
        end
    end
    assign word = mute_q ? make_frame(MIDSCALE) : make_frame(12'(bus.waveram_data) << (12 - DATA_W));
    dac_frame_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (load),
        .i_word    (word),
        .o_cs_n    (bus.dac_cs_n),
        .o_sclk    (bus.dac_sclk),
        .o_sdi     (bus.dac_sdi),
        .o_done    (done)
    );
    assign bus.waveram_read_address = addr_q;
    assign bus.waveram_read_enable = re_q;
    assign bus.dac_ldac_n = state_q != LATCH;
    assign o_busy = state_q != IDLE;
    assign o_overrun = overrun_q;
endmodule

// File: tb/tb_wave_dac_driver.sv
// tb_wave_dac_driver: directed scoreboard bench; DUT a (64/1) covers timing, stepping, enable, reset, mute
// (with DAC_MUTE_EN); DUT b (40/2) covers pending ticks and sticky overrun.
module tb_wave_dac_driver;
    localparam int SD_A = 64, S_A = 1, SD_B = 40, S_B = 2;
    logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0, en_a = 1'b1, en_b = 1'b1, mute = 1'b0;
    logic busy_a, ovr_a, busy_b, ovr_b;
    int tests = 0, fails = 0, cyc = 0, ldac_a = 0;
    logic [15:0] exp_a[$], exp_b[$];
    wave_dac_if #(.DATA_W(12)) a_if ();
    wave_dac_if #(.DATA_W(12)) b_if ();
    wave_dac_driver #(.SAMPLE_DIV(SD_A), .SCLK_DIV(S_A), .DATA_W(12)) dut_a (
        .i_clock(clk), .i_reset_n(rst_a), .i_enable(en_a), .i_mute(mute),
        .bus(a_if.master), .o_busy(busy_a), .o_overrun(ovr_a));
    wave_dac_driver #(.SAMPLE_DIV(SD_B), .SCLK_DIV(S_B), .DATA_W(12)) dut_b (
        .i_clock(clk), .i_reset_n(rst_b), .i_enable(en_b), .i_mute(1'b0),
        .bus(b_if.master), .o_busy(busy_b), .o_overrun(ovr_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [11:0] ram(input logic [12:0] a);
        return (a == 13'h0A5) ? 12'h3C9 : 12'(a * 7);
    endfunction
    always @(posedge clk) if (a_if.waveram_read_enable) a_if.waveram_data <= ram(a_if.waveram_read_address);
    always @(posedge clk) if (b_if.waveram_read_enable) b_if.waveram_data <= ram(b_if.waveram_read_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_re(input bit b, input int budget, output int stamp);
        int n = 0;
        logic re;
        do begin
            @(negedge clk);
            n++;
            re = b ? b_if.waveram_read_enable : a_if.waveram_read_enable;
        end while (!re && n < budget);
        chk(b ? "b_re_timeout" : "a_re_timeout", re, 1'b1);
        stamp = cyc;
    endtask

    // SPI decoders: frames popped against the scoreboard when CS rises; aborted frames are dropped
    logic [15:0] rx_a, rx_b;
    int nb_a, nb_b;
    int tl_a, tl_b;
    always @(negedge a_if.dac_cs_n) begin rx_a = '0; nb_a = 0; end
    always @(posedge a_if.dac_sclk) if (!a_if.dac_cs_n) begin rx_a = {rx_a[14:0], a_if.dac_sdi}; nb_a++; end
    always @(posedge a_if.dac_cs_n) if (rst_a === 1'b1) begin
        chk("a_bits", nb_a, 16);
        chk("a_sb_nonempty", exp_a.size() > 0, 1'b1);
        if (exp_a.size() > 0) chk("a_frame", rx_a, exp_a.pop_front());
    end
    always @(negedge a_if.dac_ldac_n) begin tl_a = cyc; chk("a_ldac_cs_high", a_if.dac_cs_n, 1'b1); end
    always @(posedge a_if.dac_ldac_n) if (rst_a === 1'b1) begin ldac_a++; chk("a_ldac_width", cyc - tl_a, S_A); end
    always @(negedge b_if.dac_cs_n) begin rx_b = '0; nb_b = 0; end
    always @(posedge b_if.dac_sclk) if (!b_if.dac_cs_n) begin rx_b = {rx_b[14:0], b_if.dac_sdi}; nb_b++; end
    always @(posedge b_if.dac_cs_n) if (rst_b === 1'b1) begin
        chk("b_bits", nb_b, 16);
        chk("b_sb_nonempty", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) chk("b_frame", rx_b, exp_b.pop_front());
    end
    always @(negedge b_if.dac_ldac_n) tl_b = cyc;
    always @(posedge b_if.dac_ldac_n) if (rst_b === 1'b1) chk("b_ldac_width", cyc - tl_b, S_B);

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, last, ref_c, l0;
        logic seen, saw_busy;
        a_if.waveram_address = 13'h0A5;
        b_if.waveram_address = 13'h0A5;
        repeat (3) @(negedge clk);
        chk("a_rst_cs_n", a_if.dac_cs_n, 1'b1);
        chk("a_rst_sclk", a_if.dac_sclk, 1'b0);
        chk("a_rst_sdi", a_if.dac_sdi, 1'b0);
        chk("a_rst_ldac_n", a_if.dac_ldac_n, 1'b1);
        chk("a_rst_re", a_if.waveram_read_enable, 1'b0);
        chk("a_rst_raddr", a_if.waveram_read_address, 13'h0);
        chk("a_rst_busy", busy_a, 1'b0);
        chk("a_rst_overrun", ovr_a, 1'b0);
        // fixed address, latency and repeat rate
        rst_a = 1'b1;
        ref_c = cyc;
        repeat (3) exp_a.push_back(16'h33C9);
        wait_re(0, 100, st);
        chk("a_first_tick", st - ref_c, SD_A);
        chk("a_raddr", a_if.waveram_read_address, 13'h0A5);
        @(negedge clk);
        chk("a_re_one_cycle", a_if.waveram_read_enable, 1'b0);
        chk("a_cs_still_high", a_if.dac_cs_n, 1'b1);
        chk("a_busy", busy_a, 1'b1);
        @(negedge clk);
        chk("a_cs_fall", a_if.dac_cs_n, 1'b0);
        chk("a_sclk_low_first", a_if.dac_sclk, 1'b0);
        chk("a_sdi_msb", a_if.dac_sdi, 1'b0);
        @(negedge clk);
        chk("a_sclk_first_rise", a_if.dac_sclk, 1'b1);
        repeat (2) begin
            last = st;
            wait_re(0, 100, st);
            chk("a_period", st - last, SD_A);
            chk("a_raddr_repeat", a_if.waveram_read_address, 13'h0A5);
        end
        // address stepping
        for (int k = 0; k < 4; k++) begin
            a_if.waveram_address = 13'(k);
            exp_a.push_back(16'h3000 | 16'(k * 7));
            last = st;
            wait_re(0, 100, st);
            chk("a_step_period", st - last, SD_A);
            chk("a_step_raddr", a_if.waveram_read_address, 13'(k));
        end
        chk("a_no_overrun", ovr_a, 1'b0);
        // enable dropped mid-frame
        repeat (10) @(negedge clk);
        l0 = ldac_a;
        en_a = 1'b0;
        seen = 1'b0;
        repeat (100) begin @(negedge clk); seen |= a_if.waveram_read_enable; end
        chk("a_disabled_no_re", seen, 1'b0);
        chk("a_ldac_after_disable", ldac_a - l0, 1);
        chk("a_disabled_idle", busy_a, 1'b0);
        a_if.waveram_address = 13'h0A5;
        exp_a.push_back(16'h33C9);
        en_a = 1'b1;
        ref_c = cyc;
        wait_re(0, 100, st);
        chk("a_reenable", st - ref_c, SD_A);
        // reset in the high phase of bit 8
        last = st;
        wait_re(0, 100, st);
        chk("a_period_pre_reset", st - last, SD_A);
        repeat (19) @(negedge clk);
        chk("a_bit8_sclk_high", a_if.dac_sclk, 1'b1);
        chk("a_bit8_cs_low", a_if.dac_cs_n, 1'b0);
        rst_a = 1'b0;
        #1;
        chk("a_abort_cs_n", a_if.dac_cs_n, 1'b1);
        chk("a_abort_sclk", a_if.dac_sclk, 1'b0);
        chk("a_abort_busy", busy_a, 1'b0);
        chk("a_abort_sdi", a_if.dac_sdi, 1'b0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        ref_c = cyc;
        exp_a.push_back(16'h33C9);
        wait_re(0, 100, st);
        chk("a_after_reset", st - ref_c, SD_A);
`ifdef DAC_MUTE_EN
        mute = 1'b1;
        exp_a.push_back(16'h3800);
        seen = 1'b0;
        saw_busy = 1'b0;
        repeat (66) begin
            @(negedge clk);
            seen |= a_if.waveram_read_enable;
            saw_busy |= busy_a;
        end
        chk("a_mute_no_re", seen, 1'b0);
        chk("a_mute_frame_ran", saw_busy, 1'b1);
        mute = 1'b0;
        exp_a.push_back(16'h33C9);
        last = st;
        wait_re(0, 100, st);
        chk("a_unmute_grid", st - last, 2 * SD_A);
`endif
        en_a = 1'b0;
        repeat (60) @(negedge clk);
        chk("a_sb_drained", exp_a.size(), 0);
        chk("a_end_overrun", ovr_a, 1'b0);
        rst_a = 1'b0;
        // pending and overrun with a frame longer than the sample period
        rst_b = 1'b1;
        ref_c = cyc;
        repeat (3) exp_b.push_back(16'h33C9);
        wait_re(1, 100, st);
        chk("b_first_tick", st - ref_c, SD_B);
        last = st;
        wait_re(1, 100, st);
        chk("b_pending_b2b", st - last, 3 + 33 * S_B);
        chk("b_no_overrun_yet", ovr_b, 1'b0);
        last = st;
        wait_re(1, 100, st);
        chk("b_pending_b2b_2", st - last, 3 + 33 * S_B);
        chk("b_overrun_set", ovr_b, 1'b1);
        repeat (72) @(negedge clk);
        chk("b_overrun_sticky", ovr_b, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("b_rst_overrun", ovr_b, 1'b0);
        chk("b_rst_busy", busy_b, 1'b0);
        chk("b_rst_cs_n", b_if.dac_cs_n, 1'b1);
        chk("b_sb_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
